riscv_hazard_ctrl: RTL and testbench
====================================

# riscv_hazard_ctrl

Parametrised hazard controller for the 5-stage RISC-V pipeline. It adds the following, none of which the current datapath has:
- registered forwarding selects;
- load-use stall;
- memory-wait freeze;
- branch flush, with the resolving stage selectable;
- saturating performance counters.

It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It drives their write, bubble and flush controls and the two ALU-operand forwarding muxes.

## Interface
Parameters:
- REG_AW, 5: register-index width.
- CNT_W, 32: width of each performance counter.
- BR_STAGE, 3: stage in which the branch is resolved; 2 = EX, 3 = MEM. No other value is legal.

Ports:
- clk  in  1  clock. Rising edge.
- reset  in  1  reset. Synchronous, active-low.
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1  the instruction in ID actually reads that source.
- ex_rd, mem_rd  in  REG_AW  destination registers in EX and MEM.
- ex_regwrite, mem_regwrite  in  1  the instruction in that stage writes the register file.
- ex_memread  in  1  the instruction in EX is a load.
- br_taken  in  1  a taken branch is resolved in stage BR_STAGE.
- mem_busy  in  1  data memory is not ready.
- wb_valid  in  1  a real (non-bubble) instruction is in WB.
- pc_write  out  1  PC load enable.
- if_id_write  out  1  IF/ID load enable.
- id_ex_bubble  out  1  load zeroed controls into ID/EX.
- freeze  out  1  all pipeline registers hold.
- flush_if_id, flush_id_ex, flush_ex_mem  out  1  clear that pipeline register.
- fwd_a, fwd_b  out  2  forwarding select for the EX operand:
  - 00 = register file;
  - 01 = MEM/WB result;
  - 10 = EX/MEM ALU result.
- cyc_cnt, stall_cnt, flush_cnt, retire_cnt  out  CNT_W  performance counters.

## Operation
State machine, states RUN, LU_STALL, FREEZE:
- **Load-use hazard.** Defined as: ex_memread, ex_rd≠0, and (id_use_rs1 with id_rs1=ex_rd, or id_use_rs2 with id_rs2=ex_rd).
- **RUN.**
  - mem_busy → FREEZE.
  - Otherwise br_taken → flush (state stays RUN).
  - Otherwise load-use hazard → LU_STALL.
- **Stall cycle.** Asserted combinationally in the cycle the hazard is detected. pc_write=0, if_id_write=0, id_ex_bubble=1.
- **LU_STALL.** Lasts exactly one cycle, then returns to RUN (or goes to FREEZE if mem_busy). A load-use hazard seen in LU_STALL does not stall again.
- **FREEZE.** freeze=1, pc_write=0, if_id_write=0. Stays while mem_busy=1; returns to RUN on the first cycle mem_busy=0.
- **Branch flush.** Asserted for one cycle in RUN or LU_STALL:
  - flush_if_id=1 and flush_id_ex=1;
  - flush_ex_mem=1 only when BR_STAGE=3;
  - pc_write=1 so the branch target loads.
- **Priority.** mem_busy over br_taken over load-use. br_taken is ignored while mem_busy=1; the EX/MEM register holds it stable, so it is seen again after the freeze.
- **Forwarding.** fwd_a/fwd_b are registered and computed from ID for use when the instruction reaches EX:
  - id_rs=ex_rd with ex_regwrite → 10;
  - else id_rs=mem_rd with mem_regwrite → 01;
  - else 00.
  - Register 0 never forwards. The EX match wins over the MEM match.
  - Registers update only when freeze=0. They load 00 on a stall cycle or when flush_id_ex=1.
- **Counters.** Saturate at all-ones and never wrap.
  - cyc_cnt: +1 every cycle after reset.
  - stall_cnt: +1 per stall or freeze cycle.
  - flush_cnt: +1 per flush cycle.
  - retire_cnt: +1 when wb_valid=1 and freeze=0.

## Timing
- **Reset (reset=0 at an edge).**
  - State → RUN; fwd_a/fwd_b → 00; all counters → 0.
  - While reset=0, combinational outputs are forced: pc_write=0, if_id_write=0, freeze=0, id_ex_bubble=1, all flushes=1.
- **Reset mid-stall or mid-freeze.** Abandons the state; the next cycle after release is RUN.
- **Latency.**
  - Stall, freeze and flush outputs: 0 cycles (combinational from state and inputs).
  - fwd_a/fwd_b: 1 cycle.
  - Counters: visible 1 cycle after the counted event.
- **Load-use cost.** Exactly one bubble. The consumer then forwards from MEM/WB (01).

## Structure
- Package riscv_pipe_pkg holds:
  - state enum (RUN, LU_STALL, FREEZE);
  - forwarding encodings FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- One sub-module, riscv_fwd_sel: the combinational priority compare for one operand, instantiated twice (rs1, rs2).

## Test plan
- **Back-to-back ALU dependency.** `add x5` in EX with ex_regwrite; next instruction in ID reads x5 via id_rs1 → no stall; fwd_a=10 one cycle later.
- **Load-use.** `ld x7` in EX (ex_memread=1); ID reads x7 via rs2 → one cycle with pc_write=0, id_ex_bubble=1; stall_cnt +1; next cycle fwd_b=01 and no second stall.
- **Branch flush, BR_STAGE=3.** br_taken=1 → flush_if_id, flush_id_ex and flush_ex_mem all 1 for one cycle; flush_cnt=1.
- **Branch flush, BR_STAGE=2.** Same stimulus → flush_if_id=1, flush_id_ex=1, flush_ex_mem=0.
- **Freeze.**
  - mem_busy=1 for 4 cycles with br_taken=1 → freeze=1 for 4 cycles; flushes stay 0 and stall_cnt +4.
  - After release, flush in the first RUN cycle.
- **Register 0, saturation and reset.**
  - Destination x0 produces no forward (fwd=00) and no stall.
  - With CNT_W=4, cyc_cnt holds at 15.
  - reset=0 during LU_STALL → all counters 0; state RUN after release.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared types for the 5-stage pipeline hazard logic: controller states and
// ALU-operand forwarding select encodings.
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;  // register file
    localparam logic [1:0] FWD_WB  = 2'b01;  // MEM/WB result
    localparam logic [1:0] FWD_MEM = 2'b10;  // EX/MEM ALU result

endpackage

// File: rtl/riscv_fwd_sel.sv
// Priority compare for one EX operand: the younger EX producer beats the MEM
// producer, and x0 never forwards.
module riscv_fwd_sel
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    output logic [1:0]        fwd_sel
);

    always_comb begin
        fwd_sel = FWD_RF;
        if (id_rs != '0) begin
            if (ex_regwrite && (id_rs == ex_rd)) begin
                fwd_sel = FWD_MEM;
            end else if (mem_regwrite && (id_rs == mem_rd)) begin
                fwd_sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/riscv_hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stall, memory-wait
// freeze, branch flush, registered forwarding selects and perf counters.
module riscv_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned BR_STAGE = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              ex_regwrite,
    input  logic              mem_regwrite,
    input  logic              ex_memread,
    input  logic              br_taken,
    input  logic              mem_busy,
    input  logic              wb_valid,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              freeze,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  cyc_cnt,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt,
    output logic [CNT_W-1:0]  retire_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic             FLUSH_MEM_STAGE = (BR_STAGE == 3);

    hz_state_t   state;
    hz_state_t   next_state;
    logic        lu_hazard;
    logic        stall;
    logic        flush_evt;
    logic [1:0]  sel_a;
    logic [1:0]  sel_b;

    assign lu_hazard = ex_memread && (ex_rd != '0) &&
                       ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                        (id_use_rs2 && (id_rs2 == ex_rd)));

    riscv_fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs1 (
        .id_rs        (id_rs1),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .fwd_sel      (sel_a)
    );

    riscv_fwd_sel #(.REG_AW(REG_AW)) u_fwd_rs2 (
        .id_rs        (id_rs2),
        .ex_rd        (ex_rd),
        .ex_regwrite  (ex_regwrite),
        .mem_rd       (mem_rd),
        .mem_regwrite (mem_regwrite),
        .fwd_sel      (sel_b)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // FREEZE with mem_busy low behaves as RUN in that same cycle, so a branch
    // held in EX/MEM during the freeze flushes on the first released cycle.
    always_comb begin
        next_state   = state;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        freeze       = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_ex_mem = 1'b0;
        stall        = 1'b0;
        flush_evt    = 1'b0;
        if (!reset) begin
            next_state   = RUN;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = 1'b1;
        end else if (mem_busy) begin
            next_state  = FREEZE;
            freeze      = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (br_taken) begin
            next_state   = RUN;
            flush_evt    = 1'b1;
            flush_if_id  = 1'b1;
            flush_id_ex  = 1'b1;
            flush_ex_mem = FLUSH_MEM_STAGE;
        end else if (lu_hazard && (state != LU_STALL)) begin
            next_state   = LU_STALL;
            stall        = 1'b1;
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else begin
            next_state = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fwd_a <= FWD_RF;
            fwd_b <= FWD_RF;
        end else if (!freeze) begin
            if (stall || flush_id_ex) begin
                fwd_a <= FWD_RF;
                fwd_b <= FWD_RF;
            end else begin
                fwd_a <= sel_a;
                fwd_b <= sel_b;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cyc_cnt    <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (cyc_cnt != CNT_MAX) begin
                cyc_cnt <= cyc_cnt + CNT_ONE;
            end
            if ((stall || freeze) && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (flush_evt && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
            if (wb_valid && !freeze && (retire_cnt != CNT_MAX)) begin
                retire_cnt <= retire_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Scoreboard bench for riscv_hazard_ctrl: three parameterisations share one
// directed stimulus stream; expectations are queued per cycle and checked at negedge.
module tb_riscv_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
    logic       id_use_rs1, id_use_rs2, ex_regwrite, mem_regwrite, ex_memread;
    logic       br_taken, mem_busy, wb_valid;

    logic        pc_write, if_id_write, id_ex_bubble, freeze;
    logic        flush_if_id, flush_id_ex, flush_ex_mem;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] cyc_cnt, stall_cnt, flush_cnt, retire_cnt;

    logic        b_pcw, b_ifw, b_bub, b_frz, b_fif, b_fid, b_fem;
    logic [1:0]  b_fa, b_fb;
    logic [31:0] b_cyc, b_stl, b_fls, b_ret;

    logic        c_pcw, c_ifw, c_bub, c_frz, c_fif, c_fid, c_fem;
    logic [1:0]  c_fa, c_fb;
    logic [3:0]  c_cyc, c_stl, c_fls, c_ret;

    riscv_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .BR_STAGE(3)) dut (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .ex_memread(ex_memread),
        .br_taken(br_taken), .mem_busy(mem_busy), .wb_valid(wb_valid),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
        .freeze(freeze), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .flush_ex_mem(flush_ex_mem), .fwd_a(fwd_a), .fwd_b(fwd_b), .cyc_cnt(cyc_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .retire_cnt(retire_cnt)
    );

    riscv_hazard_ctrl #(.REG_AW(5), .CNT_W(32), .BR_STAGE(2)) dut_ex (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .ex_memread(ex_memread),
        .br_taken(br_taken), .mem_busy(mem_busy), .wb_valid(wb_valid),
        .pc_write(b_pcw), .if_id_write(b_ifw), .id_ex_bubble(b_bub),
        .freeze(b_frz), .flush_if_id(b_fif), .flush_id_ex(b_fid),
        .flush_ex_mem(b_fem), .fwd_a(b_fa), .fwd_b(b_fb), .cyc_cnt(b_cyc),
        .stall_cnt(b_stl), .flush_cnt(b_fls), .retire_cnt(b_ret)
    );

    riscv_hazard_ctrl #(.REG_AW(5), .CNT_W(4), .BR_STAGE(3)) dut_c4 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd),
        .ex_regwrite(ex_regwrite), .mem_regwrite(mem_regwrite), .ex_memread(ex_memread),
        .br_taken(br_taken), .mem_busy(mem_busy), .wb_valid(wb_valid),
        .pc_write(c_pcw), .if_id_write(c_ifw), .id_ex_bubble(c_bub),
        .freeze(c_frz), .flush_if_id(c_fif), .flush_id_ex(c_fid),
        .flush_ex_mem(c_fem), .fwd_a(c_fa), .fwd_b(c_fb), .cyc_cnt(c_cyc),
        .stall_cnt(c_stl), .flush_cnt(c_fls), .retire_cnt(c_ret)
    );

    always #5 clk = ~clk;

    localparam int PCW = 0, IFW = 1, BUB = 2, FRZ = 3, FIF = 4, FID = 5, FEM = 6;
    localparam int FA = 7, FB = 8, CYC = 9, STL = 10, FLS = 11, RET = 12;
    localparam int FEM2 = 13, FID2 = 14, CYC4 = 15;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = -1;
    int   total = 0;
    int   bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sig);
        case (sig)
            PCW:     return 32'(pc_write);
            IFW:     return 32'(if_id_write);
            BUB:     return 32'(id_ex_bubble);
            FRZ:     return 32'(freeze);
            FIF:     return 32'(flush_if_id);
            FID:     return 32'(flush_id_ex);
            FEM:     return 32'(flush_ex_mem);
            FA:      return 32'(fwd_a);
            FB:      return 32'(fwd_b);
            CYC:     return cyc_cnt;
            STL:     return stall_cnt;
            FLS:     return flush_cnt;
            RET:     return retire_cnt;
            FEM2:    return 32'(b_fem);
            FID2:    return 32'(b_fid);
            CYC4:    return 32'(c_cyc);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic want(input string name, input int sig, input logic [31:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    // Monitor: every expectation tagged with the current cycle is checked here.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] a;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.cyc < cyc) begin
                bad++;
                $display("FAIL %s: cycle %0d expectation never sampled", e.name, e.cyc);
            end else begin
                a = actual(e.sig);
                if (a !== e.val) begin
                    bad++;
                    $display("FAIL %s: cycle %0d got=%0h want=%0h", e.name, e.cyc, a, e.val);
                end
            end
        end
    end

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0; mem_rd = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        ex_regwrite = 1'b0; mem_regwrite = 1'b0; ex_memread = 1'b0;
        br_taken = 1'b0; mem_busy = 1'b0; wb_valid = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();

        // C0: in reset, busy/branch must not leak through
        next_cycle();
        mem_busy = 1'b1; br_taken = 1'b1;
        want("rst_pc_write", PCW, 0);   want("rst_if_id_write", IFW, 0);
        want("rst_bubble", BUB, 1);     want("rst_freeze", FRZ, 0);
        want("rst_flush_if_id", FIF, 1); want("rst_flush_id_ex", FID, 1);
        want("rst_flush_ex_mem", FEM, 1); want("rst_flush_ex_mem_b2", FEM2, 1);
        want("rst_fwd_a", FA, 0);       want("rst_cyc", CYC, 0); want("rst_stall", STL, 0);

        // C1: released, idle
        next_cycle();
        reset = 1'b1;
        want("run_pc_write", PCW, 1); want("run_bubble", BUB, 0);
        want("run_flush_if_id", FIF, 0); want("run_cyc0", CYC, 0);

        // C2: ALU dependency on rs1 (EX) and rs2 (MEM)
        next_cycle();
        ex_rd = 5; ex_regwrite = 1; id_rs1 = 5; id_use_rs1 = 1;
        mem_rd = 6; mem_regwrite = 1; id_rs2 = 6; id_use_rs2 = 1; wb_valid = 1;
        want("alu_dep_no_stall", PCW, 1); want("alu_dep_no_bubble", BUB, 0);
        want("alu_dep_fwd_a_prev", FA, 0); want("cyc_c2", CYC, 1);

        // C3: both operands match EX and MEM; EX wins
        next_cycle();
        ex_rd = 9; ex_regwrite = 1; mem_rd = 9; mem_regwrite = 1;
        id_rs1 = 9; id_rs2 = 9; wb_valid = 1;
        want("alu_dep_fwd_a", FA, 2); want("mem_dep_fwd_b", FB, 1);
        want("retire_c3", RET, 1);    want("cyc_c3", CYC, 2);

        // C4: x0 destination: no forward and no stall even as a load
        next_cycle();
        ex_rd = 0; ex_regwrite = 1; ex_memread = 1; mem_rd = 0; mem_regwrite = 1;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 1; id_use_rs2 = 1;
        want("ex_prio_fwd_a", FA, 2); want("ex_prio_fwd_b", FB, 2);
        want("x0_no_stall", PCW, 1);  want("x0_no_bubble", BUB, 0); want("retire_c4", RET, 2);

        // C5: load-use on rs2
        next_cycle();
        ex_memread = 1; ex_rd = 7; ex_regwrite = 1; id_rs2 = 7; id_use_rs2 = 1;
        id_rs1 = 3; id_use_rs1 = 1;
        want("x0_fwd_a", FA, 0); want("x0_fwd_b", FB, 0);
        want("lu_pc_write", PCW, 0); want("lu_if_id_write", IFW, 0);
        want("lu_bubble", BUB, 1);   want("lu_freeze", FRZ, 0); want("lu_stall_before", STL, 0);

        // C6: LU_STALL; hazard still visible but must not stall again
        next_cycle();
        ex_memread = 1; ex_rd = 7; mem_rd = 7; mem_regwrite = 1; id_rs2 = 7; id_use_rs2 = 1;
        want("lu_no_second_stall", PCW, 1); want("lu_no_second_bubble", BUB, 0);
        want("lu_stall_cnt", STL, 1);       want("lu_fwd_b_bubble", FB, 0);

        // C7
        next_cycle();
        want("lu_fwd_b_wb", FB, 1); want("lu_stall_cnt_hold", STL, 1); want("lu_run_pc", PCW, 1);

        // C8: taken branch, forward request must be dropped by the flush
        next_cycle();
        br_taken = 1; ex_rd = 5; ex_regwrite = 1; id_rs1 = 5;
        want("br_flush_if_id", FIF, 1);  want("br_flush_id_ex", FID, 1);
        want("br_flush_ex_mem", FEM, 1); want("br2_flush_ex_mem", FEM2, 0);
        want("br2_flush_id_ex", FID2, 1); want("br_pc_write", PCW, 1);
        want("br_flush_cnt_before", FLS, 0);

        // C9
        next_cycle();
        want("br_one_cycle", FIF, 0); want("br_flush_ex_mem_off", FEM, 0);
        want("br_flush_cnt", FLS, 1); want("br_fwd_a_flushed", FA, 0); want("cyc_c9", CYC, 8);

        // C10..C13: memory wait with a pending branch
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            mem_busy = 1; br_taken = 1; ex_rd = 5; ex_regwrite = 1; id_rs1 = 5; wb_valid = 1;
            want("frz_freeze", FRZ, 1);   want("frz_pc_write", PCW, 0);
            want("frz_if_id_write", IFW, 0);
            want("frz_flush_if_id", FIF, 0); want("frz_flush_id_ex", FID, 0);
            want("frz_flush_ex_mem", FEM, 0);
            want("frz_stall_cnt", STL, 32'(1 + i));
            want("frz_fwd_a_hold", FA, 0); want("frz_retire_hold", RET, 2);
        end

        // C14: release, branch flushes in the first free cycle
        next_cycle();
        br_taken = 1; ex_rd = 5; ex_regwrite = 1; id_rs1 = 5; wb_valid = 1;
        want("rel_freeze", FRZ, 0);   want("rel_flush_if_id", FIF, 1);
        want("rel_flush_ex_mem", FEM, 1); want("rel_pc_write", PCW, 1);
        want("rel_stall_cnt", STL, 5); want("rel_flush_cnt_before", FLS, 1);

        // C15
        next_cycle();
        want("rel_flush_cnt", FLS, 2); want("rel_stall_hold", STL, 5);
        want("rel_retire", RET, 3);    want("rel_fwd_a", FA, 0);

        // C16: enter load-use stall
        next_cycle();
        ex_memread = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
        want("lu2_bubble", BUB, 1); want("lu2_pc_write", PCW, 0);

        // C17: reset while in LU_STALL
        next_cycle();
        reset = 1'b0;
        want("rst2_pc_write", PCW, 0); want("rst2_bubble", BUB, 1);
        want("rst2_flush_if_id", FIF, 1); want("rst2_stall_before", STL, 6);

        // C18
        next_cycle();
        reset = 1'b1;
        want("rst2_cyc", CYC, 0); want("rst2_stall", STL, 0);
        want("rst2_flush", FLS, 0); want("rst2_retire", RET, 0); want("rst2_cyc4", CYC4, 0);

        // C19: state must be RUN again, so a new hazard stalls
        next_cycle();
        ex_memread = 1; ex_rd = 7; id_rs1 = 7; id_use_rs1 = 1;
        want("rst2_run_stall", PCW, 0); want("rst2_run_bubble", BUB, 1); want("rst2_cyc1", CYC, 1);

        // C20
        next_cycle();
        want("rst2_stall_cnt", STL, 1);

        // C21..C38: idle; 4-bit cycle counter saturates at C33
        for (int k = 21; k <= 38; k++) begin
            next_cycle();
            if (k == 33) begin
                want("sat_cyc4_reach", CYC4, 15); want("cyc_c33", CYC, 15);
            end
            if (k == 38) begin
                want("sat_cyc4_hold", CYC4, 15); want("cyc_c38", CYC, 20);
            end
        end

        next_cycle();
        next_cycle();
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: left=%0d want=0", sb.size());
            bad += sb.size();
            total += sb.size();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
